// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and stall masks for the pipeline hazard sequencer.
// Stage order in the stall vector: PC, IF, ID, EX, MEM, WB.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_EX_WAIT = 1'b1
    } ex_state_t;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Request/response bundle between the pipeline and the hazard sequencer.
// master drives the hazard requests, slave returns stall/flush controls.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 6
);
    logic             id_stall_request;
    logic             ex_start;
    logic [CNT_W-1:0] ex_cycles;
    logic             mem_request;
    logic             mem_ack;
    logic             flush_request;
    logic [31:0]      flush_target;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             ex_busy;
    logic             ex_done;
    logic             mem_timeout;

    modport master (
        output id_stall_request, ex_start, ex_cycles,
        output mem_request, mem_ack, flush_request, flush_target,
        input  stall, flush, new_pc, ex_busy, ex_done, mem_timeout
    );

    modport slave (
        input  id_stall_request, ex_start, ex_cycles,
        input  mem_request, mem_ack, flush_request, flush_target,
        output stall, flush, new_pc, ex_busy, ex_done, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_controller_ex_countdown.sv
// Remaining-cycle counter for a multi-cycle EX op.
// Clear beats load beats decrement; decrement stops at zero.
module ex_countdown #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last,
    output logic             o_more
);
    logic [CNT_W-1:0] r_cnt;

    // Load on op issue, count down on every unfrozen EX cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));
    assign o_more = (r_cnt > CNT_W'(1));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer: merges load-use, multi-cycle EX, MEM wait and flush
// requests into the per-stage stall vector and the redirect pulse.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W       = 6,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_stall_controller_if.slave   bus
);
    localparam int MW = $clog2(MEM_TIMEOUT + 1);

    ex_state_t   r_state;
    ex_state_t   w_next;
    logic        w_mem_wait;
    logic        w_flush_go;
    logic        w_accept;
    logic        w_last;
    logic        w_more;
    logic        w_ex_stall;
    logic        r_flush;
    logic        r_flush_pending;
    logic [31:0] r_new_pc;
    logic [31:0] r_pend_target;
    logic [MW-1:0] r_mem_cnt;

    assign w_mem_wait = bus.mem_request & ~bus.mem_ack;
    assign w_flush_go = ~w_mem_wait & (bus.flush_request | r_flush_pending);
    assign w_accept   = (r_state == ST_IDLE) & bus.ex_start
                      & (bus.ex_cycles >= CNT_W'(2))
                      & ~w_mem_wait & ~w_flush_go & ~r_flush;

    ex_countdown #(.CNT_W(CNT_W)) u_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_clear    (w_flush_go),
        .i_load     (w_accept),
        .i_load_val (bus.ex_cycles - CNT_W'(1)),
        .i_dec      ((r_state == ST_EX_WAIT) & ~w_mem_wait),
        .o_last     (w_last),
        .o_more     (w_more)
    );

    // EX occupancy state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // EX next state and EX status outputs.
    always_comb begin
        w_next      = r_state;
        w_ex_stall  = 1'b0;
        bus.ex_busy = 1'b0;
        bus.ex_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_EX_WAIT;
                end
                w_ex_stall  = w_accept;
                bus.ex_busy = w_accept;
            end
            ST_EX_WAIT: begin
                w_ex_stall  = w_more;
                bus.ex_busy = 1'b1;
                bus.ex_done = w_last & ~w_mem_wait & ~w_flush_go;
                if (w_flush_go || (w_last && !w_mem_wait)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Widest active request wins; a flush cycle only yields to MEM.
    always_comb begin
        bus.stall = STALL_NONE;
        if (w_mem_wait) begin
            bus.stall = STALL_FROM_MEM;
        end else if (r_flush) begin
            bus.stall = STALL_NONE;
        end else if (w_ex_stall) begin
            bus.stall = STALL_FROM_EX;
        end else if (bus.id_stall_request) begin
            bus.stall = STALL_FROM_ID;
        end
    end

    // Flush issue, deferral behind MEM waits, latest target wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flush         <= 1'b0;
            r_flush_pending <= 1'b0;
            r_new_pc        <= '0;
            r_pend_target   <= '0;
        end else begin
            r_flush <= w_flush_go;
            if (w_flush_go) begin
                r_new_pc        <= bus.flush_request ? bus.flush_target
                                                     : r_pend_target;
                r_flush_pending <= 1'b0;
            end else if (bus.flush_request) begin
                r_flush_pending <= 1'b1;
                r_pend_target   <= bus.flush_target;
            end
        end
    end

    // Consecutive MEM wait counter, saturating past the timeout point.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_cnt <= '0;
        end else if (!w_mem_wait) begin
            r_mem_cnt <= '0;
        end else if (r_mem_cnt != MW'(MEM_TIMEOUT)) begin
            r_mem_cnt <= r_mem_cnt + MW'(1);
        end
    end

    assign bus.flush       = r_flush;
    assign bus.new_pc      = r_new_pc;
    assign bus.mem_timeout = w_mem_wait & (r_mem_cnt == MW'(MEM_TIMEOUT - 1));
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for the hazard sequencer: occupancy-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_pipeline_stall_controller;
    localparam int CW = 6;
    localparam int MT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

    pipeline_stall_controller #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: EX cycles still owed, consecutive waits, flush
    int          m_rem;
    int          m_mwait;
    bit          m_flush;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_ptgt;

    logic [5:0]  s_stall;
    logic        s_flush, s_busy, s_done, s_to;
    logic [31:0] s_pc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_mwait = 0; m_flush = 0; m_pend = 0;
        m_pc = '0; m_ptgt = '0;
    endtask

    task automatic drive(input bit id, input bit st, input int cyc,
                         input bit mr, input bit ma, input bit fr,
                         input logic [31:0] ft);
        bus.id_stall_request = id;
        bus.ex_start         = st;
        bus.ex_cycles        = CW'(cyc);
        bus.mem_request      = mr;
        bus.mem_ack          = ma;
        bus.flush_request    = fr;
        bus.flush_target     = ft;
    endtask

    // One clock: drive, check at negedge against the model, advance model.
    task automatic step(input bit id, input bit st, input int cyc,
                        input bit mr, input bit ma, input bit fr,
                        input logic [31:0] ft);
        bit mw, go, acc;
        logic [5:0] e_stall;
        drive(id, st, cyc, mr, ma, fr, ft);
        mw  = mr && !ma;
        go  = !mw && (fr || m_pend);
        acc = (m_rem == 0) && st && (cyc >= 2) && !mw && !go && !m_flush;
        if (mw) e_stall = 6'b011111;
        else if (m_flush) e_stall = 6'b000000;
        else if (m_rem > 1 || acc) e_stall = 6'b001111;
        else if (id) e_stall = 6'b000111;
        else e_stall = 6'b000000;
        @(negedge clock);
        s_stall = bus.stall; s_flush = bus.flush; s_busy = bus.ex_busy;
        s_done = bus.ex_done; s_to = bus.mem_timeout; s_pc = bus.new_pc;
        chk("stall", 32'(s_stall), 32'(e_stall));
        chk("flush", 32'(s_flush), 32'(m_flush));
        chk("ex_busy", 32'(s_busy), 32'(m_rem > 0 || acc));
        chk("ex_done", 32'(s_done), 32'(m_rem == 1 && !mw && !go));
        chk("mem_timeout", 32'(s_to), 32'(mw && m_mwait == MT - 1));
        if (m_flush) chk("new_pc", s_pc, m_pc);
        m_mwait = mw ? m_mwait + 1 : 0;
        if (go) m_rem = 0;
        else if (acc) m_rem = cyc - 1;
        else if (m_rem > 0 && !mw) m_rem--;
        if (go) begin
            m_pc = fr ? ft : m_ptgt;
            m_pend = 0;
            m_flush = 1;
        end else begin
            m_flush = 0;
            if (fr) begin
                m_pend = 1;
                m_ptgt = ft;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset(input string tag);
        drive(0, 0, 0, 0, 0, 0, '0);
        reset = 1'b0;
        #1;
        chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_flush"}, 32'(bus.flush), 32'h0);
        chk({tag, "_busy"}, 32'(bus.ex_busy), 32'h0);
        chk({tag, "_done"}, 32'(bus.ex_done), 32'h0);
        chk({tag, "_timeout"}, 32'(bus.mem_timeout), 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit mr, ma;
        model_reset();
        do_reset("rst");
        step(0, 0, 0, 0, 0, 0, '0);
        chk("rst_release_stall", 32'(s_stall), 32'h00);
        chk("rst_release_pc", s_pc, 32'h0);

        step(1, 0, 0, 0, 0, 0, '0);
        chk("id_stall", 32'(s_stall), 32'h07);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("id_stall_gone", 32'(s_stall), 32'h00);

        step(0, 1, 5, 0, 0, 0, '0);
        chk("ex5_c0_stall", 32'(s_stall), 32'h0f);
        chk("ex5_c0_busy", 32'(s_busy), 32'h1);
        for (int c = 1; c < 4; c++) begin
            step(0, 0, 0, 0, 0, 0, '0);
            chk("ex5_mid_stall", 32'(s_stall), 32'h0f);
        end
        step(0, 0, 0, 0, 0, 0, '0);
        chk("ex5_c4_stall", 32'(s_stall), 32'h00);
        chk("ex5_c4_done", 32'(s_done), 32'h1);
        chk("ex5_c4_busy", 32'(s_busy), 32'h1);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("ex5_c5_busy", 32'(s_busy), 32'h0);

        step(0, 1, 4, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, '0);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 1, 0, 0, '0);
            chk("ex4_memwait_stall", 32'(s_stall), 32'h1f);
            chk("ex4_memwait_done", 32'(s_done), 32'h0);
        end
        step(0, 0, 0, 1, 1, 0, '0);
        chk("ex4_ack_stall", 32'(s_stall), 32'h0f);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("ex4_late_done", 32'(s_done), 32'h1);

        step(0, 0, 0, 1, 0, 1, 32'h0040_0100);
        chk("fl_defer", 32'(s_flush), 32'h0);
        step(0, 0, 0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 1, 0, '0);
        chk("fl_ack_cycle", 32'(s_flush), 32'h0);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("fl_issue", 32'(s_flush), 32'h1);
        chk("fl_pc", s_pc, 32'h0040_0100);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("fl_once", 32'(s_flush), 32'h0);

        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 1, 0, 0, '0);
            chk("to_early", 32'(s_to), 32'h0);
        end
        step(0, 0, 0, 1, 0, 0, '0);
        chk("to_pulse", 32'(s_to), 32'h1);
        step(0, 0, 0, 1, 0, 0, '0);
        chk("to_single", 32'(s_to), 32'h0);
        idle(1);

        step(0, 1, 8, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, 0, '0);
        chk("mid_ex_busy", 32'(s_busy), 32'h1);
        do_reset("midrst");
        step(0, 0, 0, 0, 0, 0, '0);
        chk("post_rst_busy", 32'(s_busy), 32'h0);
        chk("post_rst_done", 32'(s_done), 32'h0);

        mr = 0;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset("rnd_rst");
                mr = 0;
            end
            ma = mr && ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 9)), mr, ma,
                 $urandom_range(0, 11) == 0, $urandom);
            if (ma || !mr) mr = ($urandom_range(0, 2) == 0);
            else mr = ($urandom_range(0, 9) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
